// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl: ALU control decode plus a multi-cycle multiply/divide sequencer.
// Decode maps ALUOp/funct onto the ALU op select, result mux select, jr and
// HI/LO read select. The sequencer starts an iterative MDU, holds the pipeline
// for the length of the operation and then pulses the HI/LO write enable.
// Optional feature macro: ALU_CTRL_DIV_EN (enables div and the md_op_o latch).
module alu_md_ctrl #(
  parameter int ALUOP_W   = 3,
  parameter int FUNCT_W   = 6,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [3:0]         ALU_operation_o,
  output logic [1:0]         FURslt_o,
  output logic               jr_o,
  output logic               hilo_sel_o,
  output logic               md_start_o,
  output logic               md_op_o,
  output logic               stall_o,
  output logic               hilo_we_o
);

  // Op classes coming from the main decoder
  localparam logic [ALUOP_W-1:0] OP_LWSW = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] OP_BEQ  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] OP_RTYP = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] OP_ADDI = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] OP_LUI  = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] OP_BNE  = ALUOP_W'(3'b110);

  // R-type funct codes; the upper bits of a wider funct field must be zero
  localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'b010011);
  localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'b010001);
  localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b010100);
  localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b010110);
  localparam logic [FUNCT_W-1:0] F_NOR  = FUNCT_W'(6'b010101);
  localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b110000);
  localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_SLLV = FUNCT_W'(6'b000110);
  localparam logic [FUNCT_W-1:0] F_SRLV = FUNCT_W'(6'b000100);
  localparam logic [FUNCT_W-1:0] F_MFHI = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_MULT = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_DIV  = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] F_JR   = FUNCT_W'(6'b001000);

  // Result mux selections
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_SHFT = 2'b01;
  localparam logic [1:0] RES_LUI  = 2'b10;
  localparam logic [1:0] RES_HILO = 2'b11;

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  logic             md_req;
  logic             md_div;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_c, stall_c, we_c;

  // Combinational decode of op class and funct; independent of reset and state
  always_comb begin
    ALU_operation_o = 4'b0000;
    FURslt_o        = RES_ALU;
    jr_o            = 1'b0;
    hilo_sel_o      = 1'b0;
    md_req          = 1'b0;
    md_div          = 1'b0;
    case (ALUOp_i)
      OP_RTYP: begin
        case (funct_i)
          F_ADD:  ALU_operation_o = 4'b0010;
          F_SUB:  ALU_operation_o = 4'b0110;
          F_AND:  ALU_operation_o = 4'b0000;
          F_OR:   ALU_operation_o = 4'b0001;
          F_NOR:  ALU_operation_o = 4'b1100;
          F_SLT:  ALU_operation_o = 4'b0111;
          F_SLL:  begin ALU_operation_o = 4'b0000; FURslt_o = RES_SHFT; end
          F_SRL:  begin ALU_operation_o = 4'b0001; FURslt_o = RES_SHFT; end
          F_SLLV: begin ALU_operation_o = 4'b0010; FURslt_o = RES_SHFT; end
          F_SRLV: begin ALU_operation_o = 4'b0011; FURslt_o = RES_SHFT; end
          F_MFHI: begin FURslt_o = RES_HILO; hilo_sel_o = 1'b1; end
          F_MFLO: FURslt_o = RES_HILO;
          F_MULT: md_req = 1'b1;
`ifdef ALU_CTRL_DIV_EN
          F_DIV:  begin md_req = 1'b1; md_div = 1'b1; end
`endif
          F_JR:   jr_o = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: ALU_operation_o = 4'b0010;
      OP_LUI:  FURslt_o = RES_LUI;
      OP_LWSW: ALU_operation_o = 4'b0010;
      OP_BEQ:  ALU_operation_o = 4'b0110;
      OP_BNE:  ALU_operation_o = 4'b0110;
      default: ;
    endcase
  end

  // Sequencer next-state: start from IDLE, count MD_CYCLES busy cycles, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    stall_c = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && md_req) begin
          start_c = 1'b1;
          stall_c = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        we_c    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and iteration counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control pulses are suppressed while reset is held so an aborted op never writes HI/LO
  assign md_start_o = start_c & rst_n;
  assign stall_o    = stall_c & rst_n;
  assign hilo_we_o  = we_c & rst_n;

`ifdef ALU_CTRL_DIV_EN
  logic md_op_q;

  // Latch the MDU operation (mult/div) at the start pulse; held until the next start
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      md_op_q <= 1'b0;
    end else if (start_c) begin
      md_op_q <= md_div;
    end
  end

  assign md_op_o = md_op_q;
`else
  assign md_op_o = 1'b0;
`endif

endmodule
